// File: rtl/lc_pkg.sv
// Shared definitions for the level-crossing gate sequencer.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package lc_pkg;

  // Default cycle counts. Every cycle count must be between 1 and 2**TW.
  localparam int LC_WARN_CYC  = 8;
  localparam int LC_CLEAR_CYC = 4;
  localparam int LC_MOVE_TMO  = 16;
  localparam int LC_TW        = 8;

  // The state codes are visible on the debug port, so their values are fixed.
  typedef enum logic [2:0] {
    ST_OPEN    = 3'd0,
    ST_WARN    = 3'd1,
    ST_LOWER   = 3'd2,
    ST_CLOSED  = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_RAISE   = 3'd5,
    ST_FAULT   = 3'd6,
    ST_ILLEGAL = 3'd7
  } lc_state_e;

  // Code 7 is not a real state. A corrupted register that holds it must fail
  // safe, so it is routed to FAULT on the next edge.
  function automatic logic lc_is_legal(input lc_state_e s);
    return (s != ST_ILLEGAL);
  endfunction

  // Maps an illegal code to FAULT and leaves every legal code unchanged.
  function automatic lc_state_e lc_legalize(input lc_state_e s);
    return lc_is_legal(s) ? s : ST_FAULT;
  endfunction

endpackage

// File: rtl/lc_timer.sv
// State-residence down-counter. It loads N-1 and reports done when the count reaches 0.
// Latency: the load takes effect on the next edge; done decodes the counter combinationally.
// Backpressure: none. The counter holds at 0 until the next load.
module lc_timer #(
  parameter int TW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [TW-1:0] i_value,
  output logic          o_done
);

  logic [TW-1:0] r_count;

  // Load on state entry; otherwise count down and stop at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - TW'(1);
    end
  end

  // Done means the residence budget of the current state is used up.
  always_comb begin
    o_done = (r_count == '0);
  end

endmodule

// File: rtl/gate_sequencer.sv
// Level-crossing gate sequencer. A Moore FSM drives the warning lamp, the buzzer and the gate motor.
// Latency: an input affects the outputs 1 cycle later; the outputs decode from the state register only.
// Backpressure: none. The limit switches and the motion timeout drive every decision.
module gate_sequencer
  import lc_pkg::*;
#(
  parameter int WARN_CYC  = LC_WARN_CYC,
  parameter int CLEAR_CYC = LC_CLEAR_CYC,
  parameter int MOVE_TMO  = LC_MOVE_TMO,
  parameter int TW        = LC_TW
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_train_near,
  input  logic       i_lim_down,
  input  logic       i_lim_up,
  input  logic       i_fault_clr,
  output logic       o_motor_dn,
  output logic       o_motor_up,
  output logic       o_warn_lamp,
  output logic       o_buzzer,
  output logic       o_gate_closed,
  output logic       o_fault,
  output logic [2:0] o_state
);

  // Each timer preload is N-1, so a timed state lasts exactly N cycles.
  localparam logic [TW-1:0] WARN_LD  = TW'(WARN_CYC - 1);
  localparam logic [TW-1:0] CLEAR_LD = TW'(CLEAR_CYC - 1);
  localparam logic [TW-1:0] MOVE_LD  = TW'(MOVE_TMO - 1);

  lc_state_e     r_state;
  lc_state_e     w_nxt;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_val;
  logic          w_tmr_done;
  logic          w_lim_conflict;

  // Both limit switches active at once means the switch or the wiring has failed.
  assign w_lim_conflict = i_lim_up & i_lim_down;

  // State register. Reset parks the gate open and idle immediately, even mid-motion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_OPEN;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Next-state logic. A limit-switch conflict overrides every other transition.
  always_comb begin
    w_nxt = r_state;
    if (w_lim_conflict) begin
      w_nxt = ST_FAULT;
    end else if (!lc_is_legal(r_state)) begin
      w_nxt = lc_legalize(r_state);
    end else begin
      case (r_state)
        ST_OPEN: begin
          if (i_train_near) w_nxt = ST_WARN;
        end
        ST_WARN: begin
          // Once the warning period has fully elapsed, the gate lowers.
          if (w_tmr_done)         w_nxt = ST_LOWER;
          else if (!i_train_near) w_nxt = ST_OPEN;
        end
        ST_LOWER: begin
          if (i_lim_down)      w_nxt = ST_CLOSED;
          else if (w_tmr_done) w_nxt = ST_FAULT;
        end
        ST_CLOSED: begin
          if (!i_train_near) w_nxt = ST_CLEAR;
        end
        ST_CLEAR: begin
          if (i_train_near)    w_nxt = ST_CLOSED;
          else if (w_tmr_done) w_nxt = ST_RAISE;
        end
        ST_RAISE: begin
          // A returning train must stop the raise, even with the gate already up.
          if (i_train_near)    w_nxt = ST_LOWER;
          else if (i_lim_up)   w_nxt = ST_OPEN;
          else if (w_tmr_done) w_nxt = ST_FAULT;
        end
        ST_FAULT: begin
          if (i_fault_clr) w_nxt = i_train_near ? ST_LOWER : ST_RAISE;
        end
        default: begin
          w_nxt = ST_FAULT;
        end
      endcase
    end
  end

  // Reload the timer on every state change; the preload depends on the state being entered.
  always_comb begin
    w_tmr_load = (w_nxt != r_state);
    w_tmr_val  = '0;
    case (w_nxt)
      ST_WARN:  w_tmr_val = WARN_LD;
      ST_LOWER: w_tmr_val = MOVE_LD;
      ST_RAISE: w_tmr_val = MOVE_LD;
      ST_CLEAR: w_tmr_val = CLEAR_LD;
      default:  w_tmr_val = '0;
    endcase
  end

  lc_timer #(
    .TW (TW)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_done  (w_tmr_done)
  );

  // Moore output decode. Each state drives at most one motor direction.
  always_comb begin
    o_motor_dn    = 1'b0;
    o_motor_up    = 1'b0;
    o_warn_lamp   = 1'b0;
    o_buzzer      = 1'b0;
    o_gate_closed = 1'b0;
    o_fault       = 1'b0;
    case (r_state)
      ST_WARN: begin
        o_warn_lamp = 1'b1;
        o_buzzer    = 1'b1;
      end
      ST_LOWER: begin
        o_motor_dn  = 1'b1;
        o_warn_lamp = 1'b1;
        o_buzzer    = 1'b1;
      end
      ST_CLOSED, ST_CLEAR: begin
        o_warn_lamp   = 1'b1;
        o_gate_closed = 1'b1;
      end
      ST_RAISE: begin
        o_motor_up  = 1'b1;
        o_warn_lamp = 1'b1;
      end
      ST_FAULT: begin
        o_fault     = 1'b1;
        o_warn_lamp = 1'b1;
        o_buzzer    = 1'b1;
      end
      default: begin
        o_motor_dn = 1'b0;
      end
    endcase
  end

  // Debug view of the raw state code.
  assign o_state = r_state;

endmodule

// File: tb/tb_gate_sequencer.sv
// Self-checking bench for gate_sequencer.
// Latency: a reference model steps on each rising edge; outputs are sampled 1 time unit later.
// Backpressure: n/a.
module tb_gate_sequencer;

  localparam int WARN_CYC  = 8;
  localparam int CLEAR_CYC = 4;
  localparam int MOVE_TMO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tn = 1'b0;
  logic       ld = 1'b0;
  logic       lu = 1'b0;
  logic       fc = 1'b0;
  logic       o_motor_dn, o_motor_up, o_warn_lamp, o_buzzer, o_gate_closed, o_fault;
  logic [2:0] o_state;
  wire  [5:0] w_outs = {o_motor_dn, o_motor_up, o_warn_lamp, o_buzzer, o_gate_closed, o_fault};

  int checks = 0;
  int errors = 0;

  // Reference model: the current state number and the cycles already spent in it.
  int m_st = 0;
  int m_age = 0;

  always #5 clk = ~clk;

  gate_sequencer #(
    .WARN_CYC  (WARN_CYC),
    .CLEAR_CYC (CLEAR_CYC),
    .MOVE_TMO  (MOVE_TMO),
    .TW        (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_train_near  (tn),
    .i_lim_down    (ld),
    .i_lim_up      (lu),
    .i_fault_clr   (fc),
    .o_motor_dn    (o_motor_dn),
    .o_motor_up    (o_motor_up),
    .o_warn_lamp   (o_warn_lamp),
    .o_buzzer      (o_buzzer),
    .o_gate_closed (o_gate_closed),
    .o_fault       (o_fault),
    .o_state       (o_state)
  );

  // Output table per state: {motor_dn, motor_up, warn_lamp, buzzer, gate_closed, fault}.
  function automatic logic [5:0] exp_outs(input int s);
    case (s)
      1:       return 6'b001100;
      2:       return 6'b101100;
      3, 4:    return 6'b001010;
      5:       return 6'b011000;
      6:       return 6'b001101;
      default: return 6'b000000;
    endcase
  endfunction

  // A state lasting N cycles leaves once it has already spent N-1 cycles there.
  function automatic bit used_up(input int n);
    return (m_age >= n - 1);
  endfunction

  task automatic model_step();
    int nxt;
    nxt = m_st;
    if (ld && lu) nxt = 6;
    else begin
      case (m_st)
        0: if (tn) nxt = 1;
        1: if (used_up(WARN_CYC)) nxt = 2; else if (!tn) nxt = 0;
        2: if (ld) nxt = 3; else if (used_up(MOVE_TMO)) nxt = 6;
        3: if (!tn) nxt = 4;
        4: if (tn) nxt = 3; else if (used_up(CLEAR_CYC)) nxt = 5;
        5: if (tn) nxt = 2; else if (lu) nxt = 0; else if (used_up(MOVE_TMO)) nxt = 6;
        6: if (fc) nxt = tn ? 2 : 5;
        default: nxt = 6;
      endcase
    end
    m_age = (nxt != m_st) ? 0 : m_age + 1;
    m_st  = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tn = 1'b0; ld = 1'b0; lu = 1'b0; fc = 1'b0;
    #2;
    m_st = 0; m_age = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tn = 1'b1;
    #3;
    checks++;
    if ({o_state, w_outs} !== 9'd0) begin
      errors++; $display("FAIL reset_initial got state=%0d outs=%b want state=0 outs=000000", o_state, w_outs);
    end
    #5;
    checks++;
    if ({o_state, w_outs} !== 9'd0) begin
      errors++; $display("FAIL reset_held_over_edge got state=%0d outs=%b want state=0 outs=000000", o_state, w_outs);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (o_state !== 3'd1 || w_outs !== exp_outs(1)) begin
      errors++; $display("FAIL reset_first_edge got state=%0d outs=%b want state=1 outs=%b", o_state, w_outs, exp_outs(1));
    end
    pulse_reset();
  endtask

  task automatic test_close_sequence();
    tn = 1'b1;
    for (int i = 1; i <= WARN_CYC; i++) begin
      tick();
      checks++;
      if (o_state !== 3'd1 || {o_state, w_outs} !== {m_st[2:0], exp_outs(m_st)}) begin
        errors++; $display("FAIL close_warn cyc=%0d got state=%0d outs=%b want state=1 outs=%b", i, o_state, w_outs, exp_outs(1));
      end
    end
    tick();
    checks++;
    if (o_state !== 3'd2 || o_motor_dn !== 1'b1 || o_motor_up !== 1'b0) begin
      errors++; $display("FAIL close_lower got state=%0d dn=%b up=%b want state=2 dn=1 up=0", o_state, o_motor_dn, o_motor_up);
    end
    advance(2);
    ld = 1'b1;
    tick();
    checks++;
    if (o_state !== 3'd3 || o_gate_closed !== 1'b1 || {o_state, w_outs} !== {m_st[2:0], exp_outs(m_st)}) begin
      errors++; $display("FAIL close_closed got state=%0d outs=%b want state=3 outs=%b", o_state, w_outs, exp_outs(3));
    end
  endtask

  task automatic test_clear_retrigger();
    tn = 1'b0;
    advance(2);
    tn = 1'b1;
    tick();
    checks++;
    if (o_state !== 3'd3) begin
      errors++; $display("FAIL clear_reenter_closed got state=%0d want state=3", o_state);
    end
    tn = 1'b0;
    for (int i = 1; i <= CLEAR_CYC; i++) begin
      tick();
      checks++;
      if (o_state !== 3'd4 || w_outs !== exp_outs(4)) begin
        errors++; $display("FAIL clear_wait cyc=%0d got state=%0d outs=%b want state=4 outs=%b", i, o_state, w_outs, exp_outs(4));
      end
    end
    tick();
    checks++;
    if (o_state !== 3'd5 || o_motor_up !== 1'b1 || o_motor_dn !== 1'b0) begin
      errors++; $display("FAIL clear_raise got state=%0d up=%b dn=%b want state=5 up=1 dn=0", o_state, o_motor_up, o_motor_dn);
    end
    ld = 1'b0; lu = 1'b1;
    tick();
    checks++;
    if ({o_state, w_outs} !== 9'd0) begin
      errors++; $display("FAIL clear_open got state=%0d outs=%b want state=0 outs=000000", o_state, w_outs);
    end
    lu = 1'b0;
  endtask

  task automatic test_lower_timeout();
    pulse_reset();
    tn = 1'b1;
    advance(WARN_CYC + 1);
    for (int i = 1; i < MOVE_TMO; i++) begin
      tick();
      checks++;
      if (o_state !== 3'd2 || {o_state, w_outs} !== {m_st[2:0], exp_outs(m_st)}) begin
        errors++; $display("FAIL tmo_lower cyc=%0d got state=%0d want state=2", i, o_state);
      end
    end
    tick();
    checks++;
    if (o_state !== 3'd6 || o_motor_dn !== 1'b0 || o_motor_up !== 1'b0 || o_fault !== 1'b1) begin
      errors++; $display("FAIL tmo_fault got state=%0d outs=%b want state=6 outs=%b", o_state, w_outs, exp_outs(6));
    end
    fc = 1'b1;
    tick();
    fc = 1'b0;
    checks++;
    if (o_state !== 3'd2 || o_motor_dn !== 1'b1) begin
      errors++; $display("FAIL tmo_clr_lower got state=%0d dn=%b want state=2 dn=1", o_state, o_motor_dn);
    end
  endtask

  task automatic test_raise_retrigger();
    pulse_reset();
    tn = 1'b1;
    advance(WARN_CYC + 1);
    ld = 1'b1;
    tick();
    tn = 1'b0; ld = 1'b0;
    advance(CLEAR_CYC + 1);
    checks++;
    if (o_state !== 3'd5 || o_motor_up !== 1'b1) begin
      errors++; $display("FAIL raise_reach got state=%0d up=%b want state=5 up=1", o_state, o_motor_up);
    end
    tn = 1'b1; lu = 1'b1;
    tick();
    lu = 1'b0;
    checks++;
    if (o_state !== 3'd2 || o_motor_up !== 1'b0 || o_motor_dn !== 1'b1) begin
      errors++; $display("FAIL raise_retrigger got state=%0d up=%b dn=%b want state=2 up=0 dn=1", o_state, o_motor_up, o_motor_dn);
    end
  endtask

  task automatic test_limit_conflict();
    pulse_reset();
    tn = 1'b1;
    advance(WARN_CYC + 1);
    ld = 1'b1;
    tick();
    lu = 1'b1;
    tick();
    checks++;
    if (o_state !== 3'd6 || w_outs !== exp_outs(6)) begin
      errors++; $display("FAIL conflict_fault got state=%0d outs=%b want state=6 outs=%b", o_state, w_outs, exp_outs(6));
    end
    fc = 1'b1;
    tick();
    checks++;
    if (o_state !== 3'd6) begin
      errors++; $display("FAIL conflict_over_clr got state=%0d want state=6", o_state);
    end
    lu = 1'b0; tn = 1'b0;
    tick();
    fc = 1'b0;
    checks++;
    if (o_state !== 3'd5 || o_motor_up !== 1'b1) begin
      errors++; $display("FAIL conflict_clr_raise got state=%0d want state=5", o_state);
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    tn = 1'b1;
    advance(WARN_CYC + 4);
    checks++;
    if (o_state !== 3'd2) begin
      errors++; $display("FAIL areset_setup got state=%0d want state=2", o_state);
    end
    #2;
    rst_n = 1'b0;
    #1;
    m_st = 0; m_age = 0;
    checks++;
    if ({o_state, w_outs} !== 9'd0) begin
      errors++; $display("FAIL areset_immediate got state=%0d outs=%b want state=0 outs=000000", o_state, w_outs);
    end
    @(posedge clk); #1;
    checks++;
    if ({o_state, w_outs} !== 9'd0) begin
      errors++; $display("FAIL areset_hold got state=%0d outs=%b want state=0", o_state, w_outs);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (o_state !== 3'd1) begin
      errors++; $display("FAIL areset_release got state=%0d want state=1", o_state);
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) tn = ~tn;
      ld = ($urandom_range(0, 9) == 0);
      lu = ($urandom_range(0, 9) == 0);
      fc = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if ({o_state, w_outs} !== {m_st[2:0], exp_outs(m_st)}) begin
        errors++; $display("FAIL random cyc=%0d got state=%0d outs=%b want state=%0d outs=%b", i, o_state, w_outs, m_st, exp_outs(m_st));
      end
      checks++;
      if ((o_motor_dn & o_motor_up) !== 1'b0) begin
        errors++; $display("FAIL random_motor_excl cyc=%0d got dn=%b up=%b want not both 1", i, o_motor_dn, o_motor_up);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_close_sequence();
    test_clear_retrigger();
    test_lower_timeout();
    test_raise_retrigger();
    test_limit_conflict();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
